// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin Wishbone classic arbiter with ack watchdog
module wb_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int TIMEOUT     = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_MASTERS-1:0]      m_cyc,
    input  logic [NUM_MASTERS-1:0]      m_stb,
    input  logic [NUM_MASTERS-1:0]      m_we,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr,
    input  logic [NUM_MASTERS*DW-1:0]   m_wdat,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel,
    output logic [DW-1:0]               m_rdat,
    output logic [NUM_MASTERS-1:0]      m_ack,
    output logic [NUM_MASTERS-1:0]      m_err,
    output logic                        s_cyc,
    output logic                        s_stb,
    output logic                        s_we,
    output logic [AW-1:0]               s_adr,
    output logic [DW-1:0]               s_wdat,
    output logic [DW/8-1:0]             s_sel,
    input  logic [DW-1:0]               s_rdat,
    input  logic                        s_ack,
    output logic [NUM_MASTERS-1:0]      grant
);

    localparam int SW = DW / 8;
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN   = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last;
    logic [CW-1:0] wd_cnt;

    logic [IW-1:0] pick;
    logic          pick_valid;
    logic          owner_cyc;
    logic          own_active;
    logic          wd_fire;

    // Search downward so the requester closest after 'last' is assigned last and wins.
    always_comb begin
        int j;
        pick       = last;
        pick_valid = 1'b0;
        j          = 0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            j = int'(last) + k;
            if (j >= NUM_MASTERS) begin
                j = j - NUM_MASTERS;
            end
            if (m_cyc[IW'(j)]) begin
                pick       = IW'(j);
                pick_valid = 1'b1;
            end
        end
    end

    assign owner_cyc  = m_cyc[owner];
    assign own_active = (state == ST_OWN) && owner_cyc;

    assign s_cyc  = own_active;
    assign s_stb  = own_active && m_stb[owner];
    assign s_we   = own_active && m_we[owner];
    assign s_adr  = m_adr[owner*AW +: AW];
    assign s_wdat = m_wdat[owner*DW +: DW];
    assign s_sel  = m_sel[owner*SW +: SW];
    assign m_rdat = s_rdat;

    // An ack landing on the terminal count wins over the timeout.
    assign wd_fire = (TIMEOUT != 0) && s_stb && !s_ack && (wd_cnt == TO_V);

    always_comb begin
        m_ack = '0;
        m_err = '0;
        grant = '0;
        if (s_cyc) begin
            m_ack[owner] = s_ack;
        end
        if (wd_fire) begin
            m_err[owner] = 1'b1;
        end
        if (state != ST_IDLE) begin
            grant[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            owner  <= '0;
            last   <= IW'(NUM_MASTERS - 1);
            wd_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (pick_valid) begin
                        owner <= pick;
                        last  <= pick;
                        state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (!owner_cyc) begin
                        state  <= ST_IDLE;
                        wd_cnt <= '0;
                    end else if (wd_fire) begin
                        state  <= ST_ABORT;
                        wd_cnt <= '0;
                    end else if (s_ack || !s_stb) begin
                        wd_cnt <= '0;
                    end else if ((TIMEOUT != 0) && (wd_cnt != TO_V)) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_ABORT: begin
                    wd_cnt <= '0;
                    if (!owner_cyc) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    wd_cnt <= '0;
                end
            endcase
        end
    end

endmodule
